// File: rtl/conv1_layer1_dense_ctrl_pkg.sv
// Types and constants shared by the conv1 layer1 dense datapath blocks.
package conv1_layer1_dense_ctrl_pkg;

  localparam int RES_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/conv1_layer1_dense_ctrl_fifo.sv
// Show-ahead result FIFO for adder-tree outputs; push and pop may coincide even when full.
module dense_res_fifo
  import conv1_layer1_dense_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [RES_W-1:0] wdata_i,
  input  logic             pop_i,
  output logic [RES_W-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [RES_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Storage is cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/conv1_layer1_dense_ctrl.sv
// Dense-layer issue sequencer: credit-throttled dot-product issue feeding a result FIFO.
// state    | meaning
// ST_IDLE  | waiting for cmd_start
// ST_ISSUE | issuing one dot product per cycle while credits remain
// ST_DRAIN | all issued; waiting for results to return and the FIFO to empty
// ST_DONE  | one-cycle done pulse
module conv1_layer1_dense_ctrl
  import conv1_layer1_dense_ctrl_pkg::*;
#(
  parameter int N_OUT      = 64,
  parameter int ADDR_W     = 7,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  output logic              dp_start,
  output logic              dp_halt,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [RES_W-1:0]  res_in,
  input  logic              res_in_v,
  output logic [RES_W-1:0]  out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_v,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(N_OUT + 1);
  localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = FC_W + 1;
  localparam logic [CNT_W-1:0] N_OUT_C = CNT_W'(N_OUT);
  localparam logic [SUM_W-1:0] DEPTH_C = SUM_W'(FIFO_DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  issued_q, issued_d, issued_base;
  logic [CNT_W-1:0]  received_q, received_d;
  logic [CNT_W-1:0]  popped_q, popped_d;
  logic [FC_W-1:0]   inflight_q, inflight_d;
  logic              err_q, err_d;
  logic              dp_start_q, dp_start_d;
  logic              dp_halt_q, dp_halt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [FC_W-1:0]   fifo_count;
  logic              fifo_full, fifo_empty;
  logic              push, pop, start_acc, issue;
  logic [SUM_W-1:0]  sum_next;

  always_comb begin
    pop       = !fifo_empty && out_ready;
    start_acc = (state_q == ST_IDLE) && cmd_start;
    push      = res_in_v && (inflight_q != '0) && (!fifo_full || pop);
    // A push only moves a credit from inflight to the FIFO, so only a pop frees one.
    sum_next  = SUM_W'(inflight_q) + SUM_W'(fifo_count) - SUM_W'(pop);

    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_start) state_d = ST_ISSUE;
      ST_ISSUE: if (issued_q == N_OUT_C) state_d = ST_DRAIN;
      ST_DRAIN: if ((received_q == N_OUT_C) && fifo_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered, so the issue decision is made for the next cycle.
    issued_base = start_acc ? '0 : issued_q;
    issue       = (state_d == ST_ISSUE) && (issued_base < N_OUT_C) && (sum_next < DEPTH_C);

    issued_d   = issued_base + CNT_W'(issue);
    received_d = (start_acc ? '0 : received_q) + CNT_W'(push);
    popped_d   = (start_acc ? '0 : popped_q) + CNT_W'(pop);
    inflight_d = inflight_q + FC_W'(issue) - FC_W'(push);
    err_d      = (err_q && !start_acc) || (res_in_v && !push);

    dp_start_d = issue && (issued_base == '0);
    dp_halt_d  = !issue;
    rd_addr_d  = issue ? ADDR_W'(issued_base) : rd_addr_q;
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      issued_q   <= '0;
      received_q <= '0;
      popped_q   <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
      dp_start_q <= 1'b0;
      dp_halt_q  <= 1'b1;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      popped_q   <= popped_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      dp_start_q <= dp_start_d;
      dp_halt_q  <= dp_halt_d;
      rd_addr_q  <= rd_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  dense_res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (FC_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (res_in),
    .pop_i   (pop),
    .rdata_o (out_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_v    = !fifo_empty;
  assign out_idx  = ADDR_W'(popped_q);
  assign dp_start = dp_start_q;
  assign dp_halt  = dp_halt_q;
  assign rd_addr  = rd_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_conv1_layer1_dense_ctrl.sv
// Directed bench: a 4-output instance (u_dut0) and a 64-output instance (u_dut1), each with a latency-programmable datapath model.
module tb_conv1_layer1_dense_ctrl;

  localparam int AW = 7;
  localparam logic [35:0] RST_VEC = {1'b0, 1'b1, 34'd0};

  logic clk = 1'b0;
  logic rst;
  logic          cmd_start [2];
  logic          dp_start  [2];
  logic          dp_halt   [2];
  logic [AW-1:0] rd_addr   [2];
  logic [15:0]   res_in    [2];
  logic          res_in_v  [2];
  logic [15:0]   out_data  [2];
  logic [AW-1:0] out_idx   [2];
  logic          out_v     [2];
  logic          out_ready [2];
  logic          busy      [2];
  logic          done      [2];
  logic          err       [2];

  int          lat   [2];
  logic        inj_v [2];
  logic [15:0] inj_d [2];
  logic [7:0]  vpipe [2];
  logic [15:0] dpipe [2][8];

  int total = 0;
  int bad   = 0;

  logic          ob_iss, ob_start, ob_pop, ob_done;
  logic [AW-1:0] ob_addr, ob_idx;
  logic [15:0]   ob_data;

  always #5 clk = ~clk;

  conv1_layer1_dense_ctrl #(.N_OUT(4), .ADDR_W(AW), .FIFO_DEPTH(8)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_start(cmd_start[0]), .dp_start(dp_start[0]),
    .dp_halt(dp_halt[0]), .rd_addr(rd_addr[0]), .res_in(res_in[0]), .res_in_v(res_in_v[0]),
    .out_data(out_data[0]), .out_idx(out_idx[0]), .out_v(out_v[0]), .out_ready(out_ready[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  conv1_layer1_dense_ctrl #(.N_OUT(64), .ADDR_W(AW), .FIFO_DEPTH(8)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_start(cmd_start[1]), .dp_start(dp_start[1]),
    .dp_halt(dp_halt[1]), .rd_addr(rd_addr[1]), .res_in(res_in[1]), .res_in_v(res_in_v[1]),
    .out_data(out_data[1]), .out_idx(out_idx[1]), .out_v(out_v[1]), .out_ready(out_ready[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  function automatic logic [15:0] dval(input int a);
    return 16'(a * 331 + 4660);
  endfunction

  function automatic logic [35:0] outs(input int k);
    return {dp_start[k], dp_halt[k], rd_addr[k], out_v[k], out_data[k], out_idx[k],
            busy[k], done[k], err[k]};
  endfunction

  // Datapath model: the result for an issued address appears lat[k] cycles later.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        vpipe[k] <= '0;
        for (int i = 0; i < 8; i++) dpipe[k][i] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        vpipe[k]    <= {vpipe[k][6:0], !dp_halt[k]};
        dpipe[k][0] <= dval(int'(rd_addr[k]));
        for (int i = 1; i < 8; i++) dpipe[k][i] <= dpipe[k][i-1];
      end
    end
  end

  always @* begin
    for (int k = 0; k < 2; k++) begin
      if (inj_v[k]) begin
        res_in_v[k] = 1'b1;
        res_in[k]   = inj_d[k];
      end else if (lat[k] == 0) begin
        res_in_v[k] = !dp_halt[k];
        res_in[k]   = dval(int'(rd_addr[k]));
      end else begin
        res_in_v[k] = vpipe[k][lat[k]-1];
        res_in[k]   = dpipe[k][lat[k]-1];
      end
    end
  end

  // Advance to the next falling edge, end one-cycle pulses, apply ready, and sample.
  task automatic tick(input int k, input logic rdy);
    @(negedge clk);
    cmd_start[0] = 1'b0;
    cmd_start[1] = 1'b0;
    inj_v[0]     = 1'b0;
    inj_v[1]     = 1'b0;
    out_ready[k] = rdy;
    ob_iss   = !dp_halt[k];
    ob_addr  = rd_addr[k];
    ob_start = dp_start[k];
    ob_done  = done[k];
    ob_pop   = out_v[k] && rdy;
    ob_data  = out_data[k];
    ob_idx   = out_idx[k];
  endtask

  task automatic test_reset;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (outs(k) !== RST_VEC) begin
        bad++;
        $display("FAIL reset_vals dut%0d got=%h want=%h", k, outs(k), RST_VEC);
      end
    end
    rst = 1'b1;
    tick(0, 1'b0);
    tick(0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (outs(k) !== RST_VEC) begin
        bad++;
        $display("FAIL idle_after_reset dut%0d got=%h want=%h", k, outs(k), RST_VEC);
      end
    end
  endtask

  task automatic test_basic;
    int npop, ndone;
    logic exp_iss;
    npop = 0; ndone = 0;
    lat[0] = 3;
    tick(0, 1'b1);
    cmd_start[0] = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick(0, 1'b1);
      exp_iss = (cyc <= 4);
      total++;
      if (ob_iss !== exp_iss || ob_start !== (cyc == 1) ||
          (exp_iss && ob_addr !== AW'(cyc - 1))) begin
        bad++;
        $display("FAIL basic_issue cyc=%0d got issue=%b start=%b addr=%0d want issue=%b start=%b addr=%0d",
                 cyc, ob_iss, ob_start, ob_addr, exp_iss, (cyc == 1), cyc - 1);
      end
      if (cyc == 1) begin
        total++;
        if (busy[0] !== 1'b1) begin
          bad++;
          $display("FAIL basic_busy got=%b want=1", busy[0]);
        end
      end
      if (ob_pop) begin
        total++;
        if (ob_idx !== AW'(npop) || ob_data !== dval(npop)) begin
          bad++;
          $display("FAIL basic_out got idx=%0d data=%h want idx=%0d data=%h", ob_idx, ob_data, npop, dval(npop));
        end
        npop++;
      end
      if (ob_done) ndone++;
    end
    total++;
    if (npop !== 4 || ndone !== 1) begin
      bad++;
      $display("FAIL basic_counts got pops=%0d dones=%0d want pops=4 dones=1", npop, ndone);
    end
    total++;
    if (err[0] !== 1'b0 || busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL basic_end got err=%b busy=%b want err=0 busy=0", err[0], busy[0]);
    end
  endtask

  task automatic test_backpressure;
    int n_iss, npop, ndone;
    n_iss = 0; npop = 0; ndone = 0;
    lat[1] = 2;
    tick(1, 1'b0);
    cmd_start[1] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick(1, 1'b0);
      if (ob_iss) n_iss++;
    end
    total++;
    if (n_iss !== 8) begin
      bad++;
      $display("FAIL bp_issue_count got=%0d want=8", n_iss);
    end
    total++;
    if (dp_halt[1] !== 1'b1 || out_v[1] !== 1'b1 || err[1] !== 1'b0 || busy[1] !== 1'b1) begin
      bad++;
      $display("FAIL bp_stalled got halt=%b out_v=%b err=%b busy=%b want 1 1 0 1",
               dp_halt[1], out_v[1], err[1], busy[1]);
    end
    tick(1, 1'b1);
    total++;
    if (!ob_pop || ob_idx !== AW'(0) || ob_data !== dval(0)) begin
      bad++;
      $display("FAIL bp_first_pop got pop=%b idx=%0d data=%h want pop=1 idx=0 data=%h", ob_pop, ob_idx, ob_data, dval(0));
    end
    npop = 1;
    tick(1, 1'b0);
    total++;
    if (ob_iss !== 1'b1 || ob_addr !== AW'(8)) begin
      bad++;
      $display("FAIL bp_resume got issue=%b addr=%0d want issue=1 addr=8", ob_iss, ob_addr);
    end
    n_iss = 9;
    for (int c = 0; c < 10; c++) begin
      tick(1, 1'b0);
      if (ob_iss) n_iss++;
    end
    total++;
    if (n_iss !== 9) begin
      bad++;
      $display("FAIL bp_one_credit got issues=%0d want=9", n_iss);
    end
    for (int c = 0; c < 300 && ndone == 0; c++) begin
      tick(1, 1'b1);
      if (ob_iss) n_iss++;
      if (n_iss - npop > 8) begin
        total++;
        bad++;
        $display("FAIL bp_credit got outstanding=%0d want<=8", n_iss - npop);
      end
      if (ob_pop) begin
        total++;
        if (ob_idx !== AW'(npop) || ob_data !== dval(npop)) begin
          bad++;
          $display("FAIL bp_out got idx=%0d data=%h want idx=%0d data=%h", ob_idx, ob_data, npop, dval(npop));
        end
        npop++;
      end
      if (ob_done) ndone++;
    end
    total++;
    if (ndone !== 1 || npop !== 64 || n_iss !== 64 || err[1] !== 1'b0) begin
      bad++;
      $display("FAIL bp_end got done=%0d pops=%0d issues=%0d err=%b want 1 64 64 0", ndone, npop, n_iss, err[1]);
    end
    tick(1, 1'b1);
  endtask

  task automatic test_toggle;
    int n_iss, npop, ndone, worst;
    n_iss = 0; npop = 0; ndone = 0; worst = 0;
    lat[1] = 5;
    tick(1, 1'b0);
    cmd_start[1] = 1'b1;
    for (int c = 0; c < 600 && ndone == 0; c++) begin
      tick(1, (c % 2) == 1);
      if (ob_iss) n_iss++;
      if (n_iss - npop > worst) worst = n_iss - npop;
      if (ob_pop) begin
        total++;
        if (ob_idx !== AW'(npop) || ob_data !== dval(npop)) begin
          bad++;
          $display("FAIL toggle_out got idx=%0d data=%h want idx=%0d data=%h", ob_idx, ob_data, npop, dval(npop));
        end
        npop++;
      end
      if (ob_done) ndone++;
    end
    total++;
    if (worst > 8) begin
      bad++;
      $display("FAIL toggle_credit got outstanding=%0d want<=8", worst);
    end
    total++;
    if (ndone !== 1 || npop !== 64 || err[1] !== 1'b0) begin
      bad++;
      $display("FAIL toggle_end got done=%0d pops=%0d err=%b want 1 64 0", ndone, npop, err[1]);
    end
    tick(1, 1'b1);
  endtask

  task automatic test_idle_err;
    int npop, ndone;
    logic exp_iss;
    npop = 0; ndone = 0;
    tick(0, 1'b0);
    inj_d[0] = 16'hDEAD;
    inj_v[0] = 1'b1;
    tick(0, 1'b0);
    total++;
    if (err[0] !== 1'b1 || out_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL idle_err_set got err=%b out_v=%b want err=1 out_v=0", err[0], out_v[0]);
    end
    for (int c = 0; c < 3; c++) tick(0, 1'b0);
    total++;
    if (err[0] !== 1'b1 || out_v[0] !== 1'b0 || busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL idle_err_sticky got err=%b out_v=%b busy=%b want 1 0 0", err[0], out_v[0], busy[0]);
    end
    lat[0] = 0;
    cmd_start[0] = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick(0, 1'b1);
      if (cyc == 1) begin
        total++;
        if (err[0] !== 1'b0) begin
          bad++;
          $display("FAIL idle_err_clear got err=%b want=0", err[0]);
        end
      end
      exp_iss = (cyc <= 4);
      total++;
      if (ob_iss !== exp_iss || (exp_iss && ob_addr !== AW'(cyc - 1))) begin
        bad++;
        $display("FAIL zero_lat_issue cyc=%0d got issue=%b addr=%0d want issue=%b addr=%0d",
                 cyc, ob_iss, ob_addr, exp_iss, cyc - 1);
      end
      if (ob_pop) begin
        total++;
        if (ob_idx !== AW'(npop) || ob_data !== dval(npop)) begin
          bad++;
          $display("FAIL zero_lat_out got idx=%0d data=%h want idx=%0d data=%h", ob_idx, ob_data, npop, dval(npop));
        end
        npop++;
      end
      if (ob_done) ndone++;
    end
    total++;
    if (npop !== 4 || ndone !== 1 || err[0] !== 1'b0) begin
      bad++;
      $display("FAIL zero_lat_end got pops=%0d done=%0d err=%b want 4 1 0", npop, ndone, err[0]);
    end
  endtask

  task automatic test_reset_mid;
    int n_iss, npop, ndone;
    n_iss = 0; npop = 0; ndone = 0;
    lat[1] = 3;
    tick(1, 1'b1);
    cmd_start[1] = 1'b1;
    for (int c = 0; c < 40 && n_iss < 10; c++) begin
      tick(1, 1'b1);
      if (ob_iss) n_iss++;
    end
    total++;
    if (n_iss !== 10) begin
      bad++;
      $display("FAIL rmid_reach got issues=%0d want=10", n_iss);
    end
    rst = 1'b0;
    #1;
    total++;
    if (outs(1) !== RST_VEC) begin
      bad++;
      $display("FAIL rmid_outputs got=%h want=%h", outs(1), RST_VEC);
    end
    @(negedge clk);
    rst = 1'b1;
    tick(1, 1'b1);
    cmd_start[1] = 1'b1;
    tick(1, 1'b1);
    total++;
    if (ob_iss !== 1'b1 || ob_start !== 1'b1 || ob_addr !== AW'(0)) begin
      bad++;
      $display("FAIL rmid_restart got issue=%b start=%b addr=%0d want 1 1 0", ob_iss, ob_start, ob_addr);
    end
    for (int c = 0; c < 300 && ndone == 0; c++) begin
      tick(1, 1'b1);
      if (ob_pop) begin
        total++;
        if (ob_idx !== AW'(npop) || ob_data !== dval(npop)) begin
          bad++;
          $display("FAIL rmid_out got idx=%0d data=%h want idx=%0d data=%h", ob_idx, ob_data, npop, dval(npop));
        end
        npop++;
      end
      if (ob_done) ndone++;
    end
    total++;
    if (ndone !== 1 || npop !== 64 || err[1] !== 1'b0) begin
      bad++;
      $display("FAIL rmid_end got done=%0d pops=%0d err=%b want 1 64 0", ndone, npop, err[1]);
    end
    tick(1, 1'b1);
  endtask

  task automatic test_drain_start;
    int n_iss, ndone, extra_iss, busy_bad;
    n_iss = 0; ndone = 0; extra_iss = 0; busy_bad = 0;
    lat[1] = 3;
    tick(1, 1'b1);
    cmd_start[1] = 1'b1;
    for (int c = 0; c < 100 && n_iss < 64; c++) begin
      tick(1, 1'b1);
      if (ob_iss) n_iss++;
    end
    total++;
    if (n_iss !== 64) begin
      bad++;
      $display("FAIL drain_reach got issues=%0d want=64", n_iss);
    end
    tick(1, 1'b1);
    cmd_start[1] = 1'b1;
    for (int c = 0; c < 100 && ndone == 0; c++) begin
      tick(1, 1'b1);
      if (ob_iss) extra_iss++;
      if (busy[1] !== 1'b1) busy_bad++;
      if (ob_done) ndone++;
    end
    for (int c = 0; c < 10; c++) begin
      tick(1, 1'b1);
      if (ob_iss) extra_iss++;
      if (ob_done) ndone++;
      if (busy[1] !== 1'b0) busy_bad++;
    end
    total++;
    if (ndone !== 1 || extra_iss !== 0 || busy_bad !== 0 || err[1] !== 1'b0) begin
      bad++;
      $display("FAIL drain_start got done=%0d extra_issue=%0d busy_errs=%0d err=%b want 1 0 0 0",
               ndone, extra_iss, busy_bad, err[1]);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      cmd_start[k] = 1'b0;
      out_ready[k] = 1'b0;
      inj_v[k]     = 1'b0;
      inj_d[k]     = 16'h0;
      lat[k]       = 0;
    end
    rst = 1'b0;
    #12;
    test_reset();
    test_basic();
    test_backpressure();
    test_toggle();
    test_idle_err();
    test_reset_mid();
    test_drain_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv1_layer1_dense_ctrl.md
# conv1_layer1_dense_ctrl

Sequencer for the conv1 layer1 dense datapath: global input-feature store, A-matrix store, 25-wide multiplier array, 25-wise adder tree. Issues one 25-element dot-product per cycle, throttles issue with credits so no adder-tree result is lost, and buffers results in a small FIFO. Downstream consumers read the FIFO through a valid/ready port. Sits between the layer-level scheduler and the dense datapath top.

## Interface

Parameters:
- N_OUT, 64, dot products per pass (≥1)
- ADDR_W, 7, width of store read address / output index (2^ADDR_W ≥ N_OUT)
- FIFO_DEPTH, 8, result FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cmd_start  in  1  one-cycle pulse; begins a pass when idle
- dp_start  out  1  start pulse to datapath/stores, coincident with first issue
- dp_halt  out  1  freezes stores (1 = no read this cycle)
- rd_addr  out  ADDR_W  read address for both stores, valid when dp_halt=0
- res_in  in  16  adder-tree result
- res_in_v  in  1  adder-tree result valid
- out_data  out  16  FIFO head
- out_idx  out  ADDR_W  output index of out_data (0..N_OUT-1)
- out_v  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts when out_v&out_ready
- busy  out  1  high from accepted cmd_start until done
- done  out  1  one-cycle pulse at pass end
- err  out  1  sticky protocol error; cleared by accepted cmd_start

## Operation

- FSM: IDLE → ISSUE (cmd_start) → DRAIN (issued==N_OUT) → DONE (received==N_OUT and FIFO empty) → IDLE. DONE lasts exactly one cycle and drives done=1.
- cmd_start outside IDLE: ignored, no error.
- Issue condition (ISSUE only): issued<N_OUT and inflight+fifo_count<FIFO_DEPTH. When true: dp_halt=0, rd_addr=issued, issued++, inflight++. Otherwise dp_halt=1.
- dp_start=1 only in the cycle of issue 0.
- res_in_v: push res_in, inflight--, received++. Issue and receive in the same cycle leave inflight unchanged.
- Credit rule guarantees a push never finds the FIFO full. A push when full, or res_in_v with inflight==0, sets err and drops the data; counters saturate, never wrap.
- FIFO pop on out_v&out_ready; out_idx = popped count. Push and pop in the same cycle are both legal at any occupancy, full included.
- Results return in issue order; out_idx is not carried by the datapath.
- rst low (any state): FSM→IDLE; counters, FIFO and err cleared. Datapath shares rst, so no stale results follow.

## Timing

- Reset values: dp_start=0, dp_halt=1, rd_addr=0, out_v=0, out_data=0, out_idx=0, busy=0, done=0, err=0.
- cmd_start at cycle t → ISSUE at t+1. The first issue (dp_start=1, dp_halt=0, rd_addr=0) is at t+1.
- All outputs registered, except out_data/out_idx/out_v, which are driven from FIFO registers.
- Throughput: 1 issue/cycle while credits remain. With zero datapath latency and out_ready=1, issue never stalls.
- Pass length ≥ N_OUT + datapath latency + 1 (DONE) cycles.
- busy falls in the cycle after DONE. A new cmd_start is accepted the same cycle busy=0.

## Structure

- Shared package: FSM state enum (IDLE/ISSUE/DRAIN/DONE) and the result width constant (16), shared with the adder-tree and dense top.
- One sub-module: dense_res_fifo, a synchronous FIFO of depth FIFO_DEPTH and width 16 with count output, show-ahead head.
- Top-level counters: issued, inflight, received, popped.

## Test plan

- N_OUT=4, datapath model latency 3, out_ready=1. Pulse cmd_start. Required: rd_addr 0,1,2,3 on 4 consecutive cycles; out_idx 0..3 with matching data; single done pulse; err=0.
- out_ready=0 throughout, FIFO_DEPTH=8, N_OUT=64. Required: exactly 8 issues, then dp_halt=1 held, out_v=1, no err. Raising out_ready resumes issue one credit per pop.
- out_ready toggles every cycle, latency 5. Required: all 64 results delivered in order, no err, and inflight+fifo_count never exceeds 8.
- Inject res_in_v while IDLE. Required: err=1 sticky, out_v stays 0. Next cmd_start clears err.
- Assert rst low mid-ISSUE after 10 issues. Required: all outputs at reset values immediately. Following cmd_start restarts at rd_addr=0.
- cmd_start pulsed during DRAIN. Required: ignored, exactly one done, busy unaffected.
